adc_capture_sequencer: RTL and testbench
========================================

Name: adc_capture_sequencer

Overview:
- Controller that sequences the AD9244-to-AXI-Stream capture IP by driving its 4-bit control word.
- Runs one-shot or continuous bursts of a programmed beat count, separated by a programmed gap.
- Monitors the IP's AXIS handshake to count beats, detects back-pressure stalls and drain timeouts, and reports burst status to the PS/register layer.
- Sits beside the ADC IP in the m00_axis_aclk domain.

Parameters:
- BURST_W, 16, width of burst length and beat counter.
- GAP_W, 24, width of inter-burst gap counter.
- WARMUP_CYCLES, 8, cycles between ADC enable and capture run (covers AD9244 pipeline latency).
- DRAIN_TIMEOUT, 256, max cycles in DRAIN before timeout error.
- STALL_LIMIT, 64, consecutive tvalid&!tready cycles that flag a stall.

Ports:
- m00_axis_aclk  in  1  clock.
- m00_axis_aresetn  in  1  asynchronous active-low reset.
- cfg_start  in  1  start pulse.
- cfg_abort  in  1  abort pulse.
- cfg_continuous  in  1  1 = repeat bursts, 0 = one-shot.
- cfg_burst_len  in  BURST_W  beats per burst.
- cfg_gap  in  GAP_W  idle cycles between bursts.
- err_clear  in  1  clears sticky errors.
- mon_tvalid  in  1  observed m00_axis_tvalid.
- mon_tready  in  1  observed m00_axis_tready.
- adc_control  out  4  [3] ADC enable, [0] capture run, [2:1] always 0.
- busy  out  1  state != IDLE.
- burst_done  out  1  one-cycle pulse per completed burst.
- burst_count  out  16  completed bursts, wraps at 0xFFFF→0.
- err_stall  out  1  sticky.
- err_timeout  out  1  sticky.
- err_cfg  out  1  sticky.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset is asynchronous. Reset mid-burst drops adc_control to 0 immediately.
- beat = mon_tvalid & mon_tready.
- cfg_* values are latched on an accepted start. Later cfg changes do not affect a running sequence.
- IDLE:
  - cfg_start with latched burst_len = 0: start is ignored and err_cfg is set.
  - Otherwise cfg_start → WARMUP.
  - cfg_start and cfg_abort in the same cycle: abort wins, start is ignored.
- WARMUP:
  - adc_control[3] = 1 from the first cycle after start.
  - After WARMUP_CYCLES cycles → CAPTURE.
- CAPTURE:
  - adc_control = 4'b1001.
  - Beat counter increments on each beat.
  - When a beat occurs with counter = burst_len-1: run drops on the next cycle → DRAIN.
  - Beats are never dropped or double-counted.
- DRAIN:
  - adc_control = 4'b1000.
  - Waits for the first cycle with mon_tvalid = 0.
  - If mon_tvalid is still high after DRAIN_TIMEOUT cycles: set err_timeout, go to IDLE, no burst_done.
  - Normal exit: burst_done pulses for one cycle and burst_count increments. Then:
    - continuous → GAP;
    - one-shot → IDLE, with enable dropping in the same cycle the IDLE state is entered.
- GAP:
  - adc_control = 4'b1000.
  - Counts cfg_gap cycles, then → CAPTURE directly (no warmup).
  - cfg_gap = 0 gives exactly one cycle in GAP.
- Abort in WARMUP or GAP → IDLE next cycle.
- Abort in CAPTURE → DRAIN, with the burst flagged aborted: no burst_done, no count increment.
- Abort in DRAIN is latched as the aborted flag.
- Stall detection:
  - In CAPTURE/DRAIN, STALL_LIMIT consecutive cycles of tvalid & !tready set err_stall.
  - The sequence continues.
  - The run counter resets on any cycle without a stall.
- Errors:
  - err_clear clears all sticky errors.
  - If a set condition and err_clear occur in the same cycle, set wins.
- cfg_start while busy is ignored.

Optional Feature:
- Macro: ADCSEQ_TIMESTAMP_EN.
- When defined:
  - adds a free-running 32-bit cycle counter;
  - adds output burst_timestamp [31:0], which latches the counter on the cycle CAPTURE is entered;
  - burst_timestamp resets to 0.
- When undefined: no port, no counter. All other behaviour is identical.

Decomposition:
- Package adc_seq_pkg holds:
  - state enum (IDLE, WARMUP, CAPTURE, DRAIN, GAP);
  - control bit indices CTRL_ENABLE = 3 and CTRL_RUN = 0.
- Sub-module adc_seq_stall_mon: stall run counter plus err_stall sticky logic, parameterised by STALL_LIMIT.

Test Plan:
- One-shot, burst_len = 16, tready = 1:
  - adc_control[3] rises 1 cycle after start;
  - run rises WARMUP_CYCLES later;
  - exactly 16 beats counted;
  - burst_done pulses once; burst_count = 1;
  - adc_control = 0 in IDLE.
- Continuous, burst_len = 4, gap = 10, three bursts then abort in GAP:
  - burst_count = 3;
  - run low for 10 cycles between bursts;
  - busy = 0 one cycle after abort.
- tready held low for 70 cycles mid-CAPTURE with STALL_LIMIT = 64:
  - err_stall sets at the 64th stall cycle;
  - beat count resumes correctly;
  - err_clear clears it.
- mon_tvalid held high through DRAIN:
  - err_timeout sets after 256 cycles;
  - no burst_done;
  - returns to IDLE.
- start with burst_len = 0 → err_cfg = 1, busy stays 0.
- start and abort in the same cycle → no state change.
- Reset asserted mid-CAPTURE → adc_control = 0 asynchronously, all status outputs = 0.

Source files
------------

// File: rtl/adc_capture_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// adc_seq_pkg
// Shared definitions for the ADC capture sequencer.
//   adc_seq_state_e : sequencer FSM states
//   CTRL_ENABLE     : adc_control bit that powers the ADC front end
//   CTRL_RUN        : adc_control bit that lets the capture IP stream beats
// ----------------------------------------------------------------------------
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_GAP     = 3'd4
    } adc_seq_state_e;

    localparam int unsigned CTRL_ENABLE = 3;
    localparam int unsigned CTRL_RUN    = 0;

endpackage

// File: rtl/adc_capture_sequencer_if.sv
// ----------------------------------------------------------------------------
// adc_capture_sequencer_if
// Link between the sequencer and the AD9244 capture IP.
//   adc_control : 4-bit control word into the IP ([3] enable, [0] run)
//   mon_tvalid  : observed m00_axis_tvalid of the IP
//   mon_tready  : observed m00_axis_tready of the downstream sink
// Modports:
//   master : sequencer side (drives adc_control, watches the stream)
//   slave  : capture IP side (consumes adc_control, presents the stream)
// ----------------------------------------------------------------------------
interface adc_capture_sequencer_if;

    logic [3:0] adc_control;
    logic       mon_tvalid;
    logic       mon_tready;

    modport master (
        output adc_control,
        input  mon_tvalid,
        input  mon_tready
    );

    modport slave (
        input  adc_control,
        output mon_tvalid,
        output mon_tready
    );

endinterface

// File: rtl/adc_seq_stall_mon.sv
// ----------------------------------------------------------------------------
// adc_seq_stall_mon
// Counts consecutive back-pressure cycles (tvalid & !tready) while the
// sequencer is streaming and raises a sticky stall error once STALL_LIMIT
// consecutive stall cycles have been seen.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_active     : sequencer is in CAPTURE or DRAIN
//   i_tvalid     : observed tvalid
//   i_tready     : observed tready
//   i_err_clear  : clears the sticky error (a simultaneous set wins)
//   o_err_stall  : sticky stall error
// ----------------------------------------------------------------------------
module adc_seq_stall_mon #(
    parameter int unsigned STALL_LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_tvalid,
    input  logic i_tready,
    input  logic i_err_clear,
    output logic o_err_stall
);

    localparam int unsigned CNT_W = $clog2(STALL_LIMIT + 1);

    logic             w_stall;
    logic             w_hit;
    logic [CNT_W-1:0] w_run_d;
    logic [CNT_W-1:0] r_run;
    logic             r_err;

    assign w_stall = i_active & i_tvalid & ~i_tready;
    // r_run holds the number of earlier consecutive stall cycles, so this
    // cycle is the STALL_LIMIT-th one when r_run == STALL_LIMIT-1.
    assign w_hit   = w_stall && (r_run == CNT_W'(STALL_LIMIT - 1));

    always_comb begin
        w_run_d = '0;
        if (w_stall) begin
            // Saturate: a continuing stall keeps re-asserting the error.
            w_run_d = w_hit ? r_run : r_run + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= '0;
            r_err <= 1'b0;
        end else begin
            r_run <= w_run_d;
            if (w_hit) begin
                r_err <= 1'b1;
            end else if (i_err_clear) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_err_stall = r_err;

endmodule

// File: rtl/adc_capture_sequencer.sv
// ----------------------------------------------------------------------------
// adc_capture_sequencer
// Sequences the AD9244-to-AXI-Stream capture IP through its control word:
// warm-up, capture of a programmed number of beats, drain, and an optional
// inter-burst gap for continuous operation. Counts completed bursts and
// keeps sticky stall / drain-timeout / configuration errors.
//
// Optional feature (macro ADCSEQ_TIMESTAMP_EN): free-running 32-bit cycle
// counter, sampled into burst_timestamp whenever CAPTURE is entered.
//
// Ports:
//   m00_axis_aclk, m00_axis_aresetn : clock, asynchronous active-low reset
//   cfg_start / cfg_abort           : start and abort pulses
//   cfg_continuous                  : 1 = repeat bursts, 0 = one-shot
//   cfg_burst_len, cfg_gap          : beats per burst, idle cycles between
//   err_clear                       : clears all sticky errors
//   mon_if (master)                 : adc_control out, tvalid/tready in
//   busy                            : sequence in progress
//   burst_done                      : one-cycle pulse per completed burst
//   burst_count                     : completed bursts, wrapping
//   err_stall, err_timeout, err_cfg : sticky errors
//   burst_timestamp                 : only with ADCSEQ_TIMESTAMP_EN
// ----------------------------------------------------------------------------
module adc_capture_sequencer
    import adc_seq_pkg::*;
#(
    parameter int unsigned BURST_W       = 16,
    parameter int unsigned GAP_W         = 24,
    parameter int unsigned WARMUP_CYCLES = 8,
    parameter int unsigned DRAIN_TIMEOUT = 256,
    parameter int unsigned STALL_LIMIT   = 64
) (
    input  logic                m00_axis_aclk,
    input  logic                m00_axis_aresetn,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic                cfg_continuous,
    input  logic [BURST_W-1:0]  cfg_burst_len,
    input  logic [GAP_W-1:0]    cfg_gap,
    input  logic                err_clear,
    adc_capture_sequencer_if.master mon_if,
    output logic                busy,
    output logic                burst_done,
    output logic [15:0]         burst_count,
    output logic                err_stall,
    output logic                err_timeout,
    output logic                err_cfg
`ifdef ADCSEQ_TIMESTAMP_EN
    ,
    output logic [31:0]         burst_timestamp
`endif
);

    adc_seq_state_e     r_state;
    adc_seq_state_e     w_state_d;
    // Shared cycle counter for WARMUP, DRAIN and GAP (only one is live).
    logic [GAP_W-1:0]   r_cyc_cnt;
    logic [GAP_W-1:0]   w_cyc_d;
    logic [BURST_W-1:0] r_beat_cnt;
    logic [BURST_W-1:0] w_beat_d;
    logic               r_aborted;
    logic               w_aborted_d;

    // Configuration latched on an accepted start.
    logic [BURST_W-1:0] r_len;
    logic [GAP_W-1:0]   r_gap;
    logic               r_continuous;

    logic               r_burst_done;
    logic [15:0]        r_burst_count;
    logic               r_err_timeout;
    logic               r_err_cfg;

    logic               w_beat;
    logic               w_accept;
    logic               w_cfg_set;
    logic               w_timeout_set;
    logic               w_done_set;
    logic [3:0]         w_ctrl;

    assign w_beat = mon_if.mon_tvalid & mon_if.mon_tready;

    always_comb begin
        w_state_d     = r_state;
        w_cyc_d       = r_cyc_cnt;
        w_beat_d      = r_beat_cnt;
        w_aborted_d   = r_aborted;
        w_accept      = 1'b0;
        w_cfg_set     = 1'b0;
        w_timeout_set = 1'b0;
        w_done_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Abort in the same cycle cancels the start entirely.
                if (cfg_start && !cfg_abort) begin
                    if (cfg_burst_len == '0) begin
                        w_cfg_set = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_d   = ST_WARMUP;
                        w_cyc_d     = '0;
                        w_aborted_d = 1'b0;
                    end
                end
            end
            ST_WARMUP: begin
                if (cfg_abort) begin
                    w_state_d = ST_IDLE;
                end else if (r_cyc_cnt == GAP_W'(WARMUP_CYCLES - 1)) begin
                    w_state_d = ST_CAPTURE;
                    w_beat_d  = '0;
                end else begin
                    w_cyc_d = r_cyc_cnt + GAP_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (cfg_abort) begin
                    w_state_d   = ST_DRAIN;
                    w_aborted_d = 1'b1;
                    w_cyc_d     = '0;
                end else if (w_beat) begin
                    w_beat_d = r_beat_cnt + BURST_W'(1);
                    if (r_beat_cnt == r_len - BURST_W'(1)) begin
                        w_state_d = ST_DRAIN;
                        w_cyc_d   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                w_aborted_d = r_aborted | cfg_abort;
                if (!mon_if.mon_tvalid) begin
                    w_cyc_d = '0;
                    if (w_aborted_d) begin
                        w_state_d = ST_IDLE;
                    end else begin
                        w_done_set = 1'b1;
                        w_state_d  = r_continuous ? ST_GAP : ST_IDLE;
                    end
                end else if (r_cyc_cnt == GAP_W'(DRAIN_TIMEOUT - 1)) begin
                    w_timeout_set = 1'b1;
                    w_state_d     = ST_IDLE;
                end else begin
                    w_cyc_d = r_cyc_cnt + GAP_W'(1);
                end
            end
            ST_GAP: begin
                // A zero gap still spends one cycle here.
                if (cfg_abort) begin
                    w_state_d = ST_IDLE;
                end else if (r_gap == '0 || r_cyc_cnt == r_gap - GAP_W'(1)) begin
                    w_state_d = ST_CAPTURE;
                    w_beat_d  = '0;
                end else begin
                    w_cyc_d = r_cyc_cnt + GAP_W'(1);
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_state       <= ST_IDLE;
            r_cyc_cnt     <= '0;
            r_beat_cnt    <= '0;
            r_aborted     <= 1'b0;
            r_len         <= '0;
            r_gap         <= '0;
            r_continuous  <= 1'b0;
            r_burst_done  <= 1'b0;
            r_burst_count <= '0;
            r_err_timeout <= 1'b0;
            r_err_cfg     <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cyc_cnt    <= w_cyc_d;
            r_beat_cnt   <= w_beat_d;
            r_aborted    <= w_aborted_d;
            r_burst_done <= w_done_set;
            if (w_accept) begin
                r_len        <= cfg_burst_len;
                r_gap        <= cfg_gap;
                r_continuous <= cfg_continuous;
            end
            if (w_done_set) begin
                r_burst_count <= r_burst_count + 16'd1;
            end
            if (w_timeout_set) begin
                r_err_timeout <= 1'b1;
            end else if (err_clear) begin
                r_err_timeout <= 1'b0;
            end
            if (w_cfg_set) begin
                r_err_cfg <= 1'b1;
            end else if (err_clear) begin
                r_err_cfg <= 1'b0;
            end
        end
    end

    // Control word decoded straight from state so an asynchronous reset
    // removes enable and run without waiting for a clock.
    always_comb begin
        w_ctrl              = '0;
        w_ctrl[CTRL_ENABLE] = (r_state != ST_IDLE);
        w_ctrl[CTRL_RUN]    = (r_state == ST_CAPTURE);
    end

    assign mon_if.adc_control = w_ctrl;

    adc_seq_stall_mon #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall_mon (
        .clk         (m00_axis_aclk),
        .rst_n       (m00_axis_aresetn),
        .i_active    ((r_state == ST_CAPTURE) || (r_state == ST_DRAIN)),
        .i_tvalid    (mon_if.mon_tvalid),
        .i_tready    (mon_if.mon_tready),
        .i_err_clear (err_clear),
        .o_err_stall (err_stall)
    );

`ifdef ADCSEQ_TIMESTAMP_EN
    logic [31:0] r_ts_cnt;
    logic [31:0] r_timestamp;

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_ts_cnt    <= '0;
            r_timestamp <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 32'd1;
            if (w_state_d == ST_CAPTURE && r_state != ST_CAPTURE) begin
                r_timestamp <= r_ts_cnt;
            end
        end
    end

    assign burst_timestamp = r_timestamp;
`endif

    assign busy        = (r_state != ST_IDLE);
    assign burst_done  = r_burst_done;
    assign burst_count = r_burst_count;
    assign err_timeout = r_err_timeout;
    assign err_cfg     = r_err_cfg;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// ----------------------------------------------------------------------------
// tb_adc_capture_sequencer
// Randomised self-checking bench for adc_capture_sequencer. Expected values
// come from burst-level arithmetic (beats = bursts * length, gap length,
// warm-up length, drain timeout) rather than from the FSM itself.
// ----------------------------------------------------------------------------
module tb_adc_capture_sequencer;

    localparam int unsigned WARMUP   = 8;
    localparam int unsigned DRAIN_TO = 256;
    localparam int unsigned STALL    = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic        cfg_continuous = 1'b0;
    logic [15:0] cfg_burst_len = '0;
    logic [23:0] cfg_gap = '0;
    logic        err_clear = 1'b0;
    logic        busy;
    logic        burst_done;
    logic [15:0] burst_count;
    logic        err_stall;
    logic        err_timeout;
    logic        err_cfg;
`ifdef ADCSEQ_TIMESTAMP_EN
    logic [31:0] burst_timestamp;
`endif

    adc_capture_sequencer_if u_if ();

    adc_capture_sequencer #(
        .BURST_W       (16),
        .GAP_W         (24),
        .WARMUP_CYCLES (WARMUP),
        .DRAIN_TIMEOUT (DRAIN_TO),
        .STALL_LIMIT   (STALL)
    ) u_dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rst_n),
        .cfg_start        (cfg_start),
        .cfg_abort        (cfg_abort),
        .cfg_continuous   (cfg_continuous),
        .cfg_burst_len    (cfg_burst_len),
        .cfg_gap          (cfg_gap),
        .err_clear        (err_clear),
        .mon_if           (u_if),
        .busy             (busy),
        .burst_done       (burst_done),
        .burst_count      (burst_count),
        .err_stall        (err_stall),
        .err_timeout      (err_timeout),
        .err_cfg          (err_cfg)
`ifdef ADCSEQ_TIMESTAMP_EN
        ,
        .burst_timestamp  (burst_timestamp)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Observed DUT state (used only to steer stimulus).
    logic obs_en = 1'b0;
    logic obs_run = 1'b0;
    logic obs_busy = 1'b0;

    // Stimulus knobs.
    bit rdy_rand = 1'b0;
    bit stall_mode = 1'b0;
    bit drain_hold = 1'b0;
    bit noise = 1'b0;

    // Monitors / model state.
    int beats = 0;
    int dones = 0;
    int gap_cnt = 0;
    bit measuring = 1'b0;
    bit in_drain = 1'b0;
    int drain_cycles = 0;
    int exp_gap = 1;
    int exp_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, advance past the edge, update monitors.
    task automatic tick();
        logic tv;
        logic tr;
        logic pre_run;
        if (noise) begin
            if (obs_busy) begin
                // Start and cfg changes while busy must have no effect.
                cfg_start      = ($urandom_range(7) == 0);
                cfg_burst_len  = 16'($urandom);
                cfg_gap        = 24'($urandom_range(50));
                cfg_continuous = 1'($urandom_range(1));
            end else begin
                cfg_start = 1'b0;
            end
        end
        tr = rdy_rand ? ($urandom_range(7) != 0) : 1'b1;
        if (obs_run) begin
            if (stall_mode) begin
                tv = 1'b1;
                tr = 1'b0;
            end else begin
                tv = ($urandom_range(3) != 0);
            end
        end else if (obs_en) begin
            tv = drain_hold ? 1'b1 : 1'($urandom_range(1));
        end else begin
            tv = 1'b0;
        end
        u_if.mon_tvalid = tv;
        u_if.mon_tready = tr;
        pre_run = obs_run;
        @(posedge clk);
        #1;
        obs_en   = u_if.adc_control[3];
        obs_run  = u_if.adc_control[0];
        obs_busy = busy;
        if (pre_run && tv && tr) beats++;
        if (measuring) begin
            if (obs_run) begin
                check("gap_len", gap_cnt, exp_gap);
                measuring = 1'b0;
            end else begin
                gap_cnt++;
            end
        end
        if (burst_done) begin
            dones++;
            measuring = 1'b1;
            gap_cnt   = 1;
            in_drain  = 1'b0;
        end
        if (!obs_busy) begin
            measuring = 1'b0;
            in_drain  = 1'b0;
        end
        if (pre_run && !obs_run && obs_en) in_drain = 1'b1;
        if (in_drain) drain_cycles++;
    endtask

    task automatic start_burst(input int len, input int gap, input bit cont);
        bit save;
        save           = noise;
        noise          = 1'b0;
        cfg_burst_len  = 16'(len);
        cfg_gap        = 24'(gap);
        cfg_continuous = cont;
        cfg_start      = 1'b1;
        tick();
        cfg_start      = 1'b0;
        noise          = save;
    endtask

    task automatic wait_run(input int max_cyc);
        int n;
        n = 0;
        while (!obs_run && n < max_cyc) begin
            tick();
            n++;
        end
        check("run_up", obs_run, 1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (obs_busy && n < max_cyc) begin
            tick();
            n++;
        end
        check("idle", obs_busy, 0);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    initial begin
        int b0;
        int d0;
        int n;
        int len;
        int gap;
        int nb;
        bit cont;

        u_if.mon_tvalid = 1'b0;
        u_if.mon_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ctrl", u_if.adc_control, 4'b0000);
        check("rst_busy", busy, 0);
        check("rst_done", burst_done, 0);
        check("rst_count", burst_count, 0);
        check("rst_errs", {err_stall, err_timeout, err_cfg}, 3'b000);

        // One-shot, 16 beats, sink always ready.
        rdy_rand = 1'b0;
        b0 = beats;
        d0 = dones;
        start_burst(16, 0, 0);
        check("en_rise", u_if.adc_control, 4'b1000);
        n = 0;
        while (!obs_run && n < 50) begin
            tick();
            n++;
        end
        check("warmup_len", n, WARMUP);
        check("run_ctrl", u_if.adc_control, 4'b1001);
        wait_idle(300);
        exp_count += 1;
        check("os_beats", beats - b0, 16);
        check("os_dones", dones - d0, 1);
        check("os_count", burst_count, exp_count);
        check("os_ctrl", u_if.adc_control, 4'b0000);

        // Continuous, 4 beats, gap 10, abort in the gap after three bursts.
        exp_gap = 10;
        b0 = beats;
        d0 = dones;
        start_burst(4, 10, 1);
        n = 0;
        while (dones - d0 < 3 && n < 500) begin
            tick();
            n++;
        end
        check("cont_dones", dones - d0, 3);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        exp_count += 3;
        check("abort_busy", busy, 0);
        check("abort_ctrl", u_if.adc_control, 4'b0000);
        check("cont_beats", beats - b0, 12);
        check("cont_count", burst_count, exp_count);

        // Back-pressure held 70 cycles mid-capture.
        b0 = beats;
        start_burst(40, 0, 0);
        wait_run(50);
        n = 0;
        while (beats - b0 < 5 && n < 100) begin
            tick();
            n++;
        end
        check("pre_stall", beats - b0, 5);
        stall_mode = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (k == STALL - 1) check("stall_before", err_stall, 0);
            if (k == STALL) check("stall_set", err_stall, 1);
        end
        stall_mode = 1'b0;
        wait_idle(400);
        exp_count += 1;
        check("stall_beats", beats - b0, 40);
        check("stall_count", burst_count, exp_count);
        check("stall_sticky", err_stall, 1);
        pulse_clear();
        check("stall_clear", err_stall, 0);

        // tvalid never drops during drain.
        drain_hold   = 1'b1;
        d0           = dones;
        start_burst($urandom_range(1, 8), 0, 0);
        drain_cycles = 0;
        wait_idle(600);
        drain_hold = 1'b0;
        check("to_cycles", drain_cycles, DRAIN_TO);
        check("to_err", err_timeout, 1);
        check("to_nodone", dones - d0, 0);
        check("to_count", burst_count, exp_count);
        pulse_clear();
        check("to_clear", err_timeout, 0);

        // Randomised bursts with cfg noise while busy.
        noise    = 1'b1;
        rdy_rand = 1'b1;
        for (int it = 0; it < 8; it++) begin
            len     = $urandom_range(1, 20);
            gap     = $urandom_range(0, 6);
            cont    = 1'($urandom_range(1));
            nb      = cont ? $urandom_range(1, 3) : 1;
            exp_gap = (gap == 0) ? 1 : gap;
            b0      = beats;
            d0      = dones;
            noise   = 1'b1;
            start_burst(len, gap, cont);
            if (cont) begin
                n = 0;
                while (dones - d0 < nb && n < 3000) begin
                    tick();
                    n++;
                end
                noise     = 1'b0;
                cfg_start = 1'b0;
                cfg_abort = 1'b1;
                tick();
                cfg_abort = 1'b0;
                check("rnd_abort", busy, 0);
            end else begin
                wait_idle(3000);
                noise     = 1'b0;
                cfg_start = 1'b0;
            end
            exp_count += nb;
            check("rnd_beats", beats - b0, nb * len);
            check("rnd_dones", dones - d0, nb);
            check("rnd_count", burst_count, exp_count);
        end
        rdy_rand = 1'b0;
        check("rnd_errs", {err_stall, err_timeout, err_cfg}, 3'b000);

        // Zero length: rejected with err_cfg; set beats a same-cycle clear.
        cfg_burst_len = '0;
        cfg_start     = 1'b1;
        err_clear     = 1'b1;
        tick();
        cfg_start = 1'b0;
        err_clear = 1'b0;
        check("cfg_err", err_cfg, 1);
        check("cfg_busy", busy, 0);
        tick();
        check("cfg_sticky", err_cfg, 1);
        pulse_clear();
        check("cfg_clear", err_cfg, 0);

        // Start and abort together: nothing happens.
        cfg_burst_len = 16'd5;
        cfg_start     = 1'b1;
        cfg_abort     = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        check("sa_busy", busy, 0);
        check("sa_ctrl", u_if.adc_control, 4'b0000);
        check("sa_cfg", err_cfg, 0);

        // Asynchronous reset in the middle of a capture.
        cfg_burst_len = '0;
        cfg_start     = 1'b1;
        tick();
        cfg_start = 1'b0;
        start_burst(100, 0, 0);
        wait_run(50);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_ctrl", u_if.adc_control, 4'b0000);
        check("ar_busy", busy, 0);
        check("ar_done", burst_done, 0);
        check("ar_count", burst_count, 0);
        check("ar_errs", {err_stall, err_timeout, err_cfg}, 3'b000);
        #3;
        rst_n     = 1'b1;
        exp_count = 0;
        measuring = 1'b0;
        in_drain  = 1'b0;
        tick();
        d0 = dones;
        start_burst(3, 0, 0);
        wait_idle(300);
        exp_count += 1;
        check("post_rst_count", burst_count, exp_count);
        check("post_rst_dones", dones - d0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
